program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 174 +++++++++++++++++
 tb/tb_program_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: assembles little-endian words into program memory, gates core reset.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte verified in a CHECK state.
module program_loader #(
  parameter int          MEMORY_DEPTH = 64,
  parameter logic [31:0] TEXT_BASE    = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start_i,
  input  logic        Byte_Valid_i,
  input  logic [7:0]  Byte_Data_i,
  output logic        Byte_Ready_o,
  output logic        Mem_Write_o,
  output logic [31:0] Mem_Address_o,
  output logic [31:0] Mem_Data_o,
  output logic        Core_Reset_o,
  output logic        Done_o,
  output logic        Error_o
);

  // state  | meaning
  // IDLE   | after reset, waiting for Start_i
  // LEN_LO | expecting low byte of word count
  // LEN_HI | expecting high byte of word count, then range check
  // DATA   | collecting 4 bytes of the current word
  // WRITE  | one-cycle memory write strobe
  // CHECK  | expecting checksum byte (checksum build only)
  // DONE   | program valid, core released
  // ERROR  | protocol error, core held in reset
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  localparam logic [16:0] LP_DEPTH = 17'(MEMORY_DEPTH);

  state_t      r_state;
  state_t      w_next;
  logic        w_ready;
  logic        w_accept;
  logic        w_last;
  logic        w_len_bad;
  logic [15:0] w_len_full;

  logic [7:0]  r_len_lo;
  logic [15:0] r_len;
  logic [15:0] r_index;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_data;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  assign w_accept   = Byte_Valid_i & w_ready;
  assign w_len_full = {Byte_Data_i, r_len_lo};
  assign w_len_bad  = (w_len_full == 16'd0) || ({1'b0, w_len_full} > LP_DEPTH);
  assign w_last     = (r_index == (r_len - 16'd1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start_i) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        w_ready = 1'b1;
        if (w_accept) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        w_ready = 1'b1;
        if (w_accept) w_next = w_len_bad ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        w_ready = 1'b1;
        if (w_accept && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
        w_next = w_last ? S_CHECK : S_DATA;
`else
        w_next = w_last ? S_DONE : S_DATA;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        w_ready = 1'b1;
        if (w_accept) w_next = (Byte_Data_i == r_csum) ? S_DONE : S_ERROR;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len_lo   <= 8'd0;
      r_len      <= 16'd0;
      r_index    <= 16'd0;
      r_byte_cnt <= 2'd0;
      r_addr     <= TEXT_BASE;
      r_data     <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      r_csum     <= 8'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (Start_i) begin
            r_index    <= 16'd0;
            r_byte_cnt <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len_lo <= Byte_Data_i;
`ifdef LOADER_CHECKSUM_EN
            r_csum   <= r_csum ^ Byte_Data_i;
`endif
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len  <= w_len_full;
`ifdef LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ Byte_Data_i;
`endif
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_data[{r_byte_cnt, 3'b000} +: 8] <= Byte_Data_i;
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ Byte_Data_i;
`endif
            // Address is latched as the word completes so it is stable throughout WRITE.
            if (r_byte_cnt == 2'd3) r_addr <= TEXT_BASE + {14'd0, r_index, 2'b00};
          end
        end
        S_WRITE: begin
          if (!w_last) r_index <= r_index + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign Byte_Ready_o  = w_ready;
  assign Mem_Write_o   = (r_state == S_WRITE);
  assign Mem_Address_o = r_addr;
  assign Mem_Data_o    = r_data;
  assign Done_o        = (r_state == S_DONE);
  assign Error_o       = (r_state == S_ERROR);
  assign Core_Reset_o  = (r_state != S_DONE);

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (default and LOADER_CHECKSUM_EN builds).
module tb_program_loader;

  localparam logic [31:0] TB_BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start_i = 1'b0;
  logic        Byte_Valid_i = 1'b0;
  logic [7:0]  Byte_Data_i = 8'd0;
  logic        Byte_Ready_o;
  logic        Mem_Write_o;
  logic [31:0] Mem_Address_o;
  logic [31:0] Mem_Data_o;
  logic        Core_Reset_o;
  logic        Done_o;
  logic        Error_o;

  int passed = 0;
  int total  = 0;

  int          wr_cnt = 0;
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];

  logic [7:0] stream [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

  program_loader #(.MEMORY_DEPTH(64), .TEXT_BASE(TB_BASE)) dut (
    .clk(clk), .reset(reset), .Start_i(Start_i),
    .Byte_Valid_i(Byte_Valid_i), .Byte_Data_i(Byte_Data_i), .Byte_Ready_o(Byte_Ready_o),
    .Mem_Write_o(Mem_Write_o), .Mem_Address_o(Mem_Address_o), .Mem_Data_o(Mem_Data_o),
    .Core_Reset_o(Core_Reset_o), .Done_o(Done_o), .Error_o(Error_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Mem_Write_o === 1'b1) begin
      if (wr_cnt < 8) begin
        wr_addr[wr_cnt] = Mem_Address_o;
        wr_data[wr_cnt] = Mem_Data_o;
      end
      wr_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n = 0;
    if (stall) begin
      @(negedge clk);
      Byte_Valid_i = 1'b0;
    end
    @(negedge clk);
    Byte_Valid_i = 1'b1;
    Byte_Data_i  = b;
    while (Byte_Ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 20) $display("FAIL send_byte_timeout: ready=%b after %0d cycles, required 1", Byte_Ready_o, n);
    else passed++;
    @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    Byte_Valid_i = 1'b0;
    Start_i = 1'b1;
    @(negedge clk);
    Start_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (Byte_Ready_o !== 1'b0) $display("FAIL rst_ready: got %b need 0", Byte_Ready_o); else passed++;
    total++; if (Mem_Write_o !== 1'b0) $display("FAIL rst_write: got %b need 0", Mem_Write_o); else passed++;
    total++; if (Done_o !== 1'b0) $display("FAIL rst_done: got %b need 0", Done_o); else passed++;
    total++; if (Error_o !== 1'b0) $display("FAIL rst_error: got %b need 0", Error_o); else passed++;
    total++; if (Core_Reset_o !== 1'b1) $display("FAIL rst_core_reset: got %b need 1", Core_Reset_o); else passed++;
    total++; if (Mem_Address_o !== TB_BASE) $display("FAIL rst_addr: got %h need %h", Mem_Address_o, TB_BASE); else passed++;
    total++; if (Mem_Data_o !== 32'd0) $display("FAIL rst_data: got %h need 0", Mem_Data_o); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_load(input bit stall);
    logic [7:0] cs;
    cs = 8'd0;
    wr_cnt = 0;
    pulse_start();
    total++; if (Core_Reset_o !== 1'b1) $display("FAIL load_start_core_reset: got %b need 1", Core_Reset_o); else passed++;
    total++; if (Done_o !== 1'b0) $display("FAIL load_start_done: got %b need 0", Done_o); else passed++;
    total++; if (Byte_Ready_o !== 1'b1) $display("FAIL load_start_ready: got %b need 1", Byte_Ready_o); else passed++;
    for (int i = 0; i < 10; i++) begin
      send_byte(stream[i], stall);
      cs = cs ^ stream[i];
    end
    @(negedge clk);
    Byte_Valid_i = 1'b0;
    total++; if (Mem_Write_o !== 1'b1) $display("FAIL load_last_write: got %b need 1", Mem_Write_o); else passed++;
    total++; if (Done_o !== 1'b0) $display("FAIL load_done_early: got %b need 0", Done_o); else passed++;
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs, 1'b0);
    @(negedge clk);
    Byte_Valid_i = 1'b0;
`else
    @(negedge clk);
`endif
    total++; if (Done_o !== 1'b1) $display("FAIL load_done: got %b need 1", Done_o); else passed++;
    total++; if (Core_Reset_o !== 1'b0) $display("FAIL load_core_release: got %b need 0", Core_Reset_o); else passed++;
    total++; if (Error_o !== 1'b0) $display("FAIL load_error: got %b need 0", Error_o); else passed++;
    total++; if (Mem_Write_o !== 1'b0) $display("FAIL load_write_idle: got %b need 0", Mem_Write_o); else passed++;
    total++; if (Mem_Address_o !== 32'h0040_0004) $display("FAIL load_addr_hold: got %h need 00400004", Mem_Address_o); else passed++;
    total++; if (Mem_Data_o !== 32'h0010_0593) $display("FAIL load_data_hold: got %h need 00100593", Mem_Data_o); else passed++;
    total++; if (wr_cnt !== 2) $display("FAIL load_write_count: got %0d need 2", wr_cnt); else passed++;
    if (wr_cnt >= 2) begin
      total++; if (wr_addr[0] !== 32'h0040_0000) $display("FAIL load_w0_addr: got %h need 00400000", wr_addr[0]); else passed++;
      total++; if (wr_data[0] !== 32'h00A0_0513) $display("FAIL load_w0_data: got %h need 00a00513", wr_data[0]); else passed++;
      total++; if (wr_addr[1] !== 32'h0040_0004) $display("FAIL load_w1_addr: got %h need 00400004", wr_addr[1]); else passed++;
      total++; if (wr_data[1] !== 32'h0010_0593) $display("FAIL load_w1_data: got %h need 00100593", wr_data[1]); else passed++;
    end
    repeat (3) @(negedge clk);
    total++; if (Done_o !== 1'b1) $display("FAIL load_done_sticky: got %b need 1", Done_o); else passed++;
  endtask

  task automatic test_len_errors();
    wr_cnt = 0;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    Byte_Valid_i = 1'b0;
    total++; if (Error_o !== 1'b1) $display("FAIL len0_error: got %b need 1", Error_o); else passed++;
    total++; if (Core_Reset_o !== 1'b1) $display("FAIL len0_core_reset: got %b need 1", Core_Reset_o); else passed++;
    total++; if (Done_o !== 1'b0) $display("FAIL len0_done: got %b need 0", Done_o); else passed++;
    total++; if (Byte_Ready_o !== 1'b0) $display("FAIL len0_ready: got %b need 0", Byte_Ready_o); else passed++;
    total++; if (wr_cnt !== 0) $display("FAIL len0_writes: got %0d need 0", wr_cnt); else passed++;

    pulse_start();
    send_byte(8'h41, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    Byte_Valid_i = 1'b0;
    total++; if (Error_o !== 1'b1) $display("FAIL len65_error: got %b need 1", Error_o); else passed++;

    pulse_start();
    send_byte(8'h40, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    Byte_Valid_i = 1'b0;
    total++; if (Error_o !== 1'b0) $display("FAIL len64_error: got %b need 0", Error_o); else passed++;
    total++; if (Byte_Ready_o !== 1'b1) $display("FAIL len64_ready: got %b need 1", Byte_Ready_o); else passed++;
    repeat (3) @(negedge clk);
    total++; if (Byte_Ready_o !== 1'b1) $display("FAIL len64_stall_hold: got %b need 1", Byte_Ready_o); else passed++;
    test_reset();
  endtask

  task automatic test_reset_mid();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(stream[i], 1'b0);
    @(negedge clk);
    Byte_Valid_i = 1'b0;
    reset = 1'b1;
    Start_i = 1'b1;
    @(negedge clk);
    total++; if (Byte_Ready_o !== 1'b0) $display("FAIL mid_rst_ready: got %b need 0", Byte_Ready_o); else passed++;
    total++; if (Core_Reset_o !== 1'b1) $display("FAIL mid_rst_core_reset: got %b need 1", Core_Reset_o); else passed++;
    total++; if (Mem_Data_o !== 32'd0) $display("FAIL mid_rst_data: got %h need 0", Mem_Data_o); else passed++;
    total++; if (Mem_Address_o !== TB_BASE) $display("FAIL mid_rst_addr: got %h need %h", Mem_Address_o, TB_BASE); else passed++;
    total++; if (Done_o !== 1'b0 || Error_o !== 1'b0) $display("FAIL mid_rst_flags: got done=%b err=%b need 0/0", Done_o, Error_o); else passed++;
    Start_i = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    total++; if (Byte_Ready_o !== 1'b0) $display("FAIL mid_rst_idle: got ready=%b need 0", Byte_Ready_o); else passed++;
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(stream[i], 1'b0);
    @(negedge clk);
    Byte_Valid_i = 1'b0;
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    Byte_Valid_i = 1'b0;
    total++; if (Error_o !== 1'b1) $display("FAIL csum_bad_error: got %b need 1", Error_o); else passed++;
    total++; if (Core_Reset_o !== 1'b1) $display("FAIL csum_bad_core_reset: got %b need 1", Core_Reset_o); else passed++;
    total++; if (Done_o !== 1'b0) $display("FAIL csum_bad_done: got %b need 0", Done_o); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_load(1'b0);
    test_load(1'b1);
    test_len_errors();
    test_reset_mid();
    test_load(1'b0);
`ifdef LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
